inst_rom_loader: RTL and testbench

Instruction ROM with a built-in boot loader. It sits directly upstream of the OpenMIPS core's fetch port and drives `rom_data_in` from the core's `rom_addr_out`/`rom_en`. After reset it fills its word array from a byte stream and holds the core in reset until the image is complete. It then serves combinational instruction reads so the IF/ID pipeline register captures the instruction in the same cycle the PC is presented.

---
 rtl/inst_rom_loader_if.sv | 22 ++
 rtl/inst_rom_loader.sv | 112 +++++++++++
 tb/tb_inst_rom_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_loader_if.sv
// Fetch and boot-loader bus shared between the instruction ROM and its
// upstream byte source / downstream core fetch port.
interface inst_rom_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    // Driver side: byte source plus the core's fetch request.
    modport master (
        output byte_valid, byte_data, rom_en, rom_addr,
        input  byte_ready, rom_data
    );

    // ROM side.
    modport slave (
        input  byte_valid, byte_data, rom_en, rom_addr,
        output byte_ready, rom_data
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a boot loader: fills its word array from a
// big-endian byte stream (count header, then words), holds the core in
// reset until the image is complete, then serves combinational fetches.
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    inst_rom_loader_if.slave    bus,
    input  logic                reload,
    output logic                cpu_rst_n,
    output logic                load_done,
    output logic                load_err,
    output logic [15:0]         words_loaded
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {HDR_HI, HDR_LO, DATA, RUN} state_t;

    state_t      state, state_next;
    logic [15:0] n_words;
    logic [1:0]  lane;
    logic [23:0] asm_bytes;
    logic [31:0] mem [0:DEPTH-1];

    logic        accept;
    logic        word_end;
    logic        last_word;
    logic        wr_en;
    logic [15:0] n_full;
    logic        unused_addr_lsb;

    assign accept    = bus.byte_valid && (state != RUN);
    assign word_end  = accept && (state == DATA) && (lane == 2'd3);
    assign last_word = ({1'b0, words_loaded} + 17'd1) == {1'b0, n_words};
    assign wr_en     = word_end && (32'(words_loaded) < DEPTH);
    assign n_full    = {n_words[15:8], bus.byte_data};
    assign unused_addr_lsb = &{1'b0, bus.rom_addr[1:0]};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HDR_HI;
        else        state <= state_next;
    end

    // Next-state decode and loader handshake.
    always_comb begin
        state_next     = state;
        bus.byte_ready = 1'b1;
        case (state)
            HDR_HI: if (accept) state_next = HDR_LO;
            HDR_LO: if (accept) state_next = (n_full == 16'd0) ? RUN : DATA;
            DATA:   if (word_end && last_word) state_next = RUN;
            RUN: begin
                bus.byte_ready = 1'b0;
                if (reload) state_next = HDR_HI;
            end
            default: state_next = HDR_HI;
        endcase
    end

    // Header capture, word assembly, counters and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_words      <= '0;
            lane         <= '0;
            asm_bytes    <= '0;
            words_loaded <= '0;
            load_err     <= 1'b0;
            load_done    <= 1'b0;
            cpu_rst_n    <= 1'b0;
        end else begin
            // Core reset and done flag track RUN entry/exit on the same edge.
            cpu_rst_n <= (state_next == RUN);
            load_done <= (state_next == RUN);
            case (state)
                HDR_HI: if (accept) n_words[15:8] <= bus.byte_data;
                HDR_LO: if (accept) begin
                    n_words[7:0] <= bus.byte_data;
                    lane         <= '0;
                    words_loaded <= '0;
                    if (32'(n_full) > DEPTH) load_err <= 1'b1;
                end
                DATA: if (accept) begin
                    lane <= lane + 2'd1;
                    if (lane != 2'd3)
                        asm_bytes <= {asm_bytes[15:0], bus.byte_data};
                    else if (words_loaded != 16'hFFFF)
                        words_loaded <= words_loaded + 16'd1;
                end
                RUN: if (reload) begin
                    load_err     <= 1'b0;
                    words_loaded <= '0;
                    lane         <= '0;
                end
                default: ;
            endcase
        end
    end

    // Word array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[words_loaded[ADDR_W-1:0]] <= {asm_bytes, bus.byte_data};
    end

    // Combinational fetch, gated to zero outside RUN or the mapped range.
    always_comb begin
        bus.rom_data = '0;
        if (bus.rom_en && (bus.rom_addr[31:ADDR_W+2] == '0) && (state == RUN))
            bus.rom_data = mem[bus.rom_addr[ADDR_W+1:2]];
    end
endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader with a small (4-word) array.
module tb_inst_rom_loader;
    logic        clk;
    logic        rst_n;
    logic        reload;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int unsigned total;
    int unsigned passed;
    int unsigned failed;
    logic [31:0] exp_q[$];

    inst_rom_loader_if bus ();

    inst_rom_loader #(.ADDR_W(2)) u_dut (
        .clk          (clk),
        .reset        (rst_n),
        .bus          (bus),
        .reload       (reload),
        .cpu_rst_n    (cpu_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Push expected fetch result, present the address, compare away from the edge.
    task automatic rd(input string tag, input logic en, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        bus.rom_en   = en;
        bus.rom_addr = addr;
        @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, bus.rom_data, e);
        bus.rom_en = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        repeat ($urandom_range(0, max_gap)) @(posedge clk);
        #1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned max_gap);
        logic [31:0] t;
        t = w;
        for (int unsigned i = 0; i < 4; i++) begin
            send_byte(t[31:24], max_gap);
            t = t << 8;
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic basic_image(input int unsigned gap, input string tag);
        send_byte(8'h00, gap);
        send_byte(8'h02, gap);
        send_word(32'h34010010, gap);
        send_byte(8'h34, gap);
        send_byte(8'h02, gap);
        send_byte(8'h00, gap);
        chk({tag, "_pre_rst"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_pre_ready"}, 32'(bus.byte_ready), 32'd1);
        rd({tag, "_load_rd"}, 1'b1, 32'h0, 32'h0);
        send_byte(8'h20, gap);
        chk({tag, "_rst_n"}, 32'(cpu_rst_n), 32'd1);
        chk({tag, "_done"}, 32'(load_done), 32'd1);
        chk({tag, "_words"}, 32'(words_loaded), 32'd2);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        rd({tag, "_rd0"}, 1'b1, 32'h0, 32'h34010010);
        rd({tag, "_rd4"}, 1'b1, 32'h4, 32'h34020020);
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        rst_n = 1'b0; reload = 1'b0;
        bus.byte_valid = 1'b0; bus.byte_data = '0;
        bus.rom_en = 1'b1; bus.rom_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.byte_ready), 32'd1);
        chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        rd("rst_rd", 1'b1, 32'h0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        basic_image(0, "basic");

        rd("gate_en", 1'b0, 32'h0, 32'h0);
        rd("gate_hi", 1'b1, 32'h0001_0000, 32'h0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        chk("run_bytes_words", 32'(words_loaded), 32'd2);
        chk("run_bytes_cpu", 32'(cpu_rst_n), 32'd1);
        rd("run_bytes_rd0", 1'b1, 32'h0, 32'h34010010);

        pulse_reload();
        chk("reload_cpu", 32'(cpu_rst_n), 32'd0);
        chk("reload_ready", 32'(bus.byte_ready), 32'd1);
        chk("reload_done", 32'(load_done), 32'd0);
        chk("reload_words", 32'(words_loaded), 32'd0);
        send_byte(8'h00, 2);
        send_byte(8'h01, 2);
        send_word(32'hDEADBEEF, 2);
        chk("rl_cpu", 32'(cpu_rst_n), 32'd1);
        chk("rl_words", 32'(words_loaded), 32'd1);
        rd("rl_rd0", 1'b1, 32'h0, 32'hDEADBEEF);
        rd("rl_rd4", 1'b1, 32'h4, 32'h34020020);

        pulse_reload();
        basic_image(3, "gap");

        pulse_reload();
        send_byte(8'h00, 0);
        chk("zero_mid_cpu", 32'(cpu_rst_n), 32'd0);
        send_byte(8'h00, 0);
        chk("zero_cpu", 32'(cpu_rst_n), 32'd1);
        chk("zero_done", 32'(load_done), 32'd1);
        chk("zero_words", 32'(words_loaded), 32'd0);
        rd("zero_rd0", 1'b1, 32'h0, 32'h34010010);

        pulse_reload();
        send_byte(8'h00, 1);
        send_byte(8'h05, 1);
        chk("oor_err_hdr", 32'(load_err), 32'd1);
        for (int unsigned i = 1; i <= 5; i++) send_word({4{8'(i * 8'h11)}}, 1);
        chk("oor_err", 32'(load_err), 32'd1);
        chk("oor_words", 32'(words_loaded), 32'd5);
        chk("oor_cpu", 32'(cpu_rst_n), 32'd1);
        for (int unsigned i = 0; i < 4; i++)
            rd("oor_rd", 1'b1, 32'(i * 4), {4{8'((i + 1) * 8'h11)}});
        rd("oor_rd16", 1'b1, 32'd16, 32'h0);

        pulse_reload();
        chk("reload_err_clr", 32'(load_err), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.byte_ready), 32'd1);
        chk("mid_rst_cpu", 32'(cpu_rst_n), 32'd0);
        chk("mid_rst_words", 32'(words_loaded), 32'd0);
        chk("mid_rst_done", 32'(load_done), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hCAFEF00D, 0);
        chk("mid_rst_cpu_up", 32'(cpu_rst_n), 32'd1);
        rd("mid_rst_rd0", 1'b1, 32'h0, 32'hCAFEF00D);
        rd("mid_rst_rd4", 1'b1, 32'h4, 32'h22222222);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
